// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter: shift-and-add-3, one input bit per clock.
// Optional leading-zero blanking of the loaded result when BCD_BLANK_EN is defined.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   work;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   nxt_work;
    logic [BIN_W-1:0]   nxt_shreg;
    logic               top_bit;
    logic               fin_ovf;
    logic [BCD_W-1:0]   load;
    logic [3:0]         dig;

    // One shift-and-add-3 step; digits adjust independently, no inter-digit carry.
    always_comb begin
        adj = '0;
        dig = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dig = work[4*d +: 4];
            adj[4*d +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
        end
        nxt_work  = {adj[BCD_W-2:0], shreg[BIN_W-1]};
        nxt_shreg = {shreg[BIN_W-2:0], 1'b0};
        top_bit   = adj[BCD_W-1];
        fin_ovf   = ovf | top_bit;
    end

`ifdef BCD_BLANK_EN
    logic lead;

    // Result to load: saturate on overflow, else blank zeros above the top non-zero digit.
    always_comb begin
        load = nxt_work;
        lead = 1'b1;
        if (fin_ovf) begin
            load = {DIGITS{4'h9}};
        end else begin
            for (int d = DIGITS - 1; d > 0; d--) begin
                if (lead && (nxt_work[4*d +: 4] == 4'h0)) begin
                    load[4*d +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end
`else
    // Result to load: saturate to all nines on overflow.
    always_comb begin
        load = nxt_work;
        if (fin_ovf) begin
            load = {DIGITS{4'h9}};
        end
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            shreg    <= '0;
            work     <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= binary;
                        work  <= '0;
                        ovf   <= 1'b0;
                        cnt   <= CNT_W'(BIN_W);
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    shreg <= nxt_shreg;
                    work  <= nxt_work;
                    ovf   <= fin_ovf;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd      <= load;
                        overflow <= fin_ovf;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: 3-digit and 2-digit instances, BIN_W=8.
// Expected results come from a decimal reference model; BCD_BLANK_EN selects blanking.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start3 = 1'b0;
    logic [7:0]  bin3 = '0;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;

    logic        start2 = 1'b0;
    logic [7:0]  bin2 = '0;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;

    int checks = 0;
    int fails = 0;

    logic [12:0] q3[$];
    logic [8:0]  q2[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .binary(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .binary(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
    );

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", n, got, exp);
        end
    endfunction

    // Decimal reference: {overflow, bcd}; digit extraction by division.
    function automatic logic [12:0] model(int v, int nd);
        logic [11:0] b;
        int x;
        logic lead;
        b = '0;
        x = v;
        if (v >= ((nd == 2) ? 100 : 1000)) begin
            for (int i = 0; i < nd; i++) b[4*i +: 4] = 4'h9;
            return {1'b1, b};
        end
        for (int i = 0; i < nd; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_BLANK_EN
        lead = 1'b1;
        for (int i = nd - 1; i > 0; i--) begin
            if (lead && b[4*i +: 4] == 4'h0) b[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return {lead & 1'b0, b};
    endfunction

    // Monitor for the 3-digit instance.
    int bc3 = 0;
    logic pd3 = 1'b0;
    logic [11:0] hb3 = '0;
    logic ho3 = 1'b0;
    always @(negedge clk) begin
        logic [12:0] e;
        if (!rst_n) begin
            bc3 = 0; pd3 = 1'b0; hb3 = '0; ho3 = 1'b0;
        end else begin
            if (busy3) bc3++;
            if (done3) begin
                chk("d3_single_pulse", 32'(pd3), 0);
                if (q3.size() == 0) begin
                    chk("d3_spurious_done", 1, 0);
                end else begin
                    e = q3.pop_front();
                    chk("d3_bcd", 32'(bcd3), 32'(e[11:0]));
                    chk("d3_overflow", 32'(ovf3), 32'(e[12]));
                    chk("d3_busy_cycles", bc3, 8);
                end
                bc3 = 0; hb3 = bcd3; ho3 = ovf3;
            end else begin
                chk("d3_bcd_held", 32'(bcd3), 32'(hb3));
                chk("d3_ovf_held", 32'(ovf3), 32'(ho3));
            end
            pd3 = done3;
        end
    end

    // Monitor for the 2-digit instance.
    int bc2 = 0;
    logic pd2 = 1'b0;
    logic [7:0] hb2 = '0;
    logic ho2 = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            bc2 = 0; pd2 = 1'b0; hb2 = '0; ho2 = 1'b0;
        end else begin
            if (busy2) bc2++;
            if (done2) begin
                chk("d2_single_pulse", 32'(pd2), 0);
                if (q2.size() == 0) begin
                    chk("d2_spurious_done", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("d2_bcd", 32'(bcd2), 32'(e[7:0]));
                    chk("d2_overflow", 32'(ovf2), 32'(e[8]));
                    chk("d2_busy_cycles", bc2, 8);
                end
                bc2 = 0; hb2 = bcd2; ho2 = ovf2;
            end else begin
                chk("d2_bcd_held", 32'(bcd2), 32'(hb2));
                chk("d2_ovf_held", 32'(ovf2), 32'(ho2));
            end
            pd2 = done2;
        end
    end

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? busy2 : busy3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_bound", 32'(n < 50), 1);
    endtask

    task automatic push(input bit sel, input int v);
        logic [12:0] m;
        m = model(v, sel ? 2 : 3);
        if (sel) q2.push_back({m[12], m[7:0]});
        else q3.push_back(m);
    endtask

    task automatic go(input bit sel, input logic [7:0] v);
        wait_idle(sel);
        if (sel) begin start2 = 1'b1; bin2 = v; end
        else begin start3 = 1'b1; bin3 = v; end
        push(sel, int'(v));
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
        wait_idle(sel);
    endtask

    initial begin
        int n;
        int m;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy3), 0);
        chk("rst_done", 32'(done3), 0);
        chk("rst_bcd", 32'(bcd3), 0);
        chk("rst_overflow", 32'(ovf3), 0);
        rst_n = 1'b1;
        @(negedge clk);

        go(1'b0, 8'd255);

        // Back-to-back: start held through the first done.
        start3 = 1'b1; bin3 = 8'd0; push(1'b0, 0);
        @(negedge clk);
        bin3 = 8'd99; push(1'b0, 99);
        n = 0;
        while (!done3 && n < 30) begin @(negedge clk); n++; end
        chk("b2b_first_done_seen", 32'(done3), 1);
        @(negedge clk);
        start3 = 1'b0;
        m = 1;
        while (!done3 && m < 30) begin @(negedge clk); m++; end
        chk("b2b_gap", m, 9);
        wait_idle(1'b0);

        go(1'b0, 8'd7);
        go(1'b0, 8'd40);
        go(1'b0, 8'd100);
        go(1'b1, 8'd123);
        go(1'b1, 8'd42);
        go(1'b1, 8'd200);
        go(1'b1, 8'd99);
        go(1'b1, 8'd100);
        go(1'b1, 8'd0);

        // Start pulses and input toggling while busy are ignored.
        wait_idle(1'b0);
        start3 = 1'b1; bin3 = 8'd173; push(1'b0, 173);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start3 = 1'($urandom_range(0, 1));
            bin3 = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        start3 = 1'b0;
        wait_idle(1'b0);

        // Reset in the middle of a conversion aborts it.
        start3 = 1'b1; bin3 = 8'd200;
        @(negedge clk);
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy3), 0);
        chk("abort_done", 32'(done3), 0);
        chk("abort_bcd", 32'(bcd3), 0);
        chk("abort_overflow", 32'(ovf3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done_bcd", 32'(bcd3), 0);
        go(1'b0, 8'd200);

        for (int v = 0; v < 256; v++) go(1'b0, 8'(v));
        for (int v = 0; v < 256; v++) go(1'b1, 8'(v));

        repeat (3) @(negedge clk);
        chk("q3_drained", q3.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
